// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous SRAM bank between instruction fetch and data ports.
// Each access is sequenced as a multi-cycle strobe waveform ending in a one-cycle ack.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ack,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_WREC, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SW-1:0]     r_starve;
  logic [WW-1:0]     r_wait;
  logic              r_own;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_irdata;
  logic [31:0]       r_drdata;
  logic              w_inst_win;
  logic              w_grant_d;
  logic              w_last;

  // r_own: 1 = data port owns the current access
  assign w_inst_win = inst_req && (!data_req || r_starve == SLIM);
  assign w_grant_d  = data_req && !w_inst_win;
  assign w_last     = (r_wait == WLAST);

  always_comb begin
    w_next     = r_state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = 4'hF;
    sram_dq_oe = 1'b0;
    inst_ack   = 1'b0;
    data_ack   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_d)
          w_next = data_we ? S_WRITE : S_READ;
        else if (w_inst_win)
          w_next = S_READ;
      end
      S_READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'h0;
        if (w_last) w_next = S_DONE;
      end
      S_WRITE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_be_n  = ~r_be;
        sram_dq_oe = 1'b1;
        if (w_last) w_next = S_WREC;
      end
      S_WREC: begin
        sram_ce_n  = 1'b0;
        sram_be_n  = ~r_be;
        sram_dq_oe = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        inst_ack = !r_own;
        data_ack = r_own;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
      r_wait   <= '0;
      r_own    <= 1'b0;
      r_be     <= 4'h0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_wait <= '0;
        if (w_grant_d) begin
          r_own   <= 1'b1;
          r_be    <= data_be;
          r_addr  <= data_addr;
          r_wdata <= data_wdata;
        end else if (w_inst_win) begin
          r_own  <= 1'b0;
          r_addr <= inst_addr;
        end
        if (w_inst_win || (w_grant_d && !inst_req))
          r_starve <= '0;
        else if (w_grant_d && r_starve != SLIM)
          r_starve <= r_starve + 1'b1;
      end else if (r_state == S_READ || r_state == S_WRITE) begin
        r_wait <= w_last ? '0 : r_wait + 1'b1;
        // the pad is sampled at the end of the final strobe cycle
        if (r_state == S_READ && w_last) begin
          if (r_own) r_drdata <= sram_dq_i;
          else       r_irdata <= sram_dq_i;
        end
      end
    end
  end

  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_wdata;
  assign inst_rdata = r_irdata;
  assign data_rdata = r_drdata;

endmodule
